// File: rtl/uart_pkg.sv
// Shared state encoding and default constants for the UART transmit path.
package uart_pkg;

  localparam int UART_WIDTH        = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_FETCH,
    TX_WAIT,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // States that put a timed bit on the line.
  function automatic logic is_bit_state(tx_state_t s);
    return (s == TX_START) || (s == TX_DATA) || (s == TX_PARITY) || (s == TX_STOP);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: reload starts a new bit, bit_end marks its last clock.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            load_i,
  output logic [$clog2(CLKS_PER_BIT)-1:0] cnt_o,
  output logic                            bit_end_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (load_i) begin
      cnt_o <= CNT_W'(CLKS_PER_BIT - 1);
    end else if (cnt_o != '0) begin
      cnt_o <= cnt_o - 1'b1;
    end
  end

  assign bit_end_o = (cnt_o == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops bytes from the TX FIFO and serialises them.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int WIDTH        = UART_WIDTH,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             parity_odd_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_d_ready_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_re_o,
  output logic             fifo_tr_bz_o,
  output logic             txd_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt;
  logic             bit_end;
  logic             load;
  logic             start_ok;
  logic             par_bit;
  logic             txd_d, busy_d, done_d;

  assign start_ok = enable_i && !fifo_empty_i;

`ifdef UART_TX_PARITY_EN
  logic par_q;

  // Data parity is captured with the byte; odd/even selection is applied on output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      par_q <= 1'b0;
    end else if (state_q == TX_WAIT && fifo_d_ready_i) begin
      par_q <= ^fifo_rdata_i;
    end
  end

  assign par_bit = par_q ^ parity_odd_i;
`else
  logic unused_parity_odd;

  assign unused_parity_odd = parity_odd_i;
  assign par_bit           = 1'b0;
`endif

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (load),
    .cnt_o    (cnt),
    .bit_end_o(bit_end)
  );

  // Reload on entry to every bit, whether from a non-bit state or at a bit boundary.
  assign load = is_bit_state(state_d) && (bit_end || !is_bit_state(state_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches are inferred.
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    case (state_q)
      TX_IDLE: begin
        if (start_ok) state_d = TX_FETCH;
      end
      TX_FETCH: begin
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (fifo_d_ready_i) begin
          shreg_d = fifo_rdata_i;
          state_d = TX_START;
        end else if (!fifo_empty_i) begin
          state_d = TX_FETCH;
        end else begin
          state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (bit_end) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) state_d = TX_STOP;
      end
      TX_STOP: begin
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            idx_d   = '0;
            state_d = start_ok ? TX_FETCH : TX_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they align with it.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = shreg_d[0];
      TX_PARITY: txd_d = par_bit;
      default:   txd_d = 1'b1;
    endcase
    busy_d = (state_d != TX_IDLE);
    done_d = (state_q == TX_STOP) && (cnt == CNT_W'(1)) && (idx_q == LAST_STOP);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      txd_o  <= 1'b1;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      txd_o  <= txd_d;
      busy_o <= busy_d;
      done_o <= done_d;
    end
  end

  assign fifo_re_o    = (state_q == TX_FETCH);
  assign fifo_tr_bz_o = !((state_q == TX_IDLE) || (state_q == TX_FETCH));

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a small queue-based FIFO model.
// Builds with or without UART_TX_PARITY_EN.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  // Expected line bits, written MSB..LSB as {stop, parity, data[7:0], start}.
  localparam logic [11:0] F_01 = 12'b0_1_1_00000001_0;
  localparam logic [11:0] F_80 = 12'b0_1_1_10000000_0;
  localparam logic [11:0] F_A5 = 12'b0_1_0_10100101_0;
  localparam logic [11:0] F_3C = 12'b0_1_0_00111100_0;
  localparam logic [11:0] F_0F = 12'b0_1_0_00001111_0;
`else
  localparam int NBITS = 10;
  localparam logic [11:0] F_01 = 12'b00_1_00000001_0;
  localparam logic [11:0] F_80 = 12'b00_1_10000000_0;
  localparam logic [11:0] F_A5 = 12'b00_1_10100101_0;
  localparam logic [11:0] F_3C = 12'b00_1_00111100_0;
  localparam logic [11:0] F_0F = 12'b00_1_00001111_0;
`endif
  localparam int FRAME_CLKS = NBITS * CPB;
  localparam int NVEC = 7;

  typedef struct {
    logic [7:0]  data;
    logic        odd;
    logic [11:0] bits;
  } vec_t;

  logic       clk_i = 1'b0;
  logic       rst_i, enable_i, parity_odd_i, fifo_empty_i, fifo_d_ready_i;
  logic [7:0] fifo_rdata_i;
  logic       fifo_re_o, fifo_tr_bz_o, txd_o, busy_o, done_o;

  uart_tx_ctrl #(
    .WIDTH       (8),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .parity_odd_i  (parity_odd_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_d_ready_i(fifo_d_ready_i),
    .fifo_rdata_i  (fifo_rdata_i),
    .fifo_re_o     (fifo_re_o),
    .fifo_tr_bz_o  (fifo_tr_bz_o),
    .txd_o         (txd_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  int         n_vec;
  int         n_fail;
  logic [7:0] fifo_q[$];
  logic       fetch_pending;
  logic       force_empty;
  int         withhold;
  int         pops;
  int         fetches;
  vec_t       vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty_i = force_empty;
  endtask

  // One clock: answer a pending pop, then sample DUT outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
    fifo_d_ready_i = 1'b0;
    fifo_rdata_i   = 8'hEE;
    if (fetch_pending) begin
      if (withhold > 0) begin
        withhold = withhold - 1;
      end else if (fifo_q.size() > 0) begin
        fifo_d_ready_i = 1'b1;
        fifo_rdata_i   = fifo_q.pop_front();
        pops++;
      end
    end
    fetch_pending = fifo_re_o;
    if (fifo_re_o) fetches++;
    fifo_empty_i = force_empty || (fifo_q.size() == 0);
  endtask

  task automatic run_frame(input string tag, input logic [11:0] exp_bits,
                           input int exp_lat, input int drop_en_at);
    int           lat;
    int           done_seen;
    int           done_idx;
    logic [CPB-1:0] samp;
    lat = 0;
    while (txd_o !== 1'b0 && lat < 20) begin
      tick();
      lat++;
    end
    check($sformatf("%s start latency", tag), lat, exp_lat);
    if (txd_o !== 1'b0) return;
    done_seen = 0;
    done_idx  = -1;
    samp      = '0;
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) tick();
        if (b * CPB + c == drop_en_at) enable_i = 1'b0;
        samp[c] = txd_o;
        if (done_o === 1'b1) begin
          done_seen++;
          done_idx = b * CPB + c;
        end
      end
      check($sformatf("%s bit%0d", tag, b), samp, {CPB{exp_bits[b]}});
    end
    check($sformatf("%s done pulses", tag), done_seen, 1);
    check($sformatf("%s done clock", tag), done_idx, FRAME_CLKS - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0, lat;
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, 1'b0, 12'b0_1_0_10100101_0};
    vecs[1] = '{8'hA5, 1'b1, 12'b0_1_1_10100101_0};
    vecs[2] = '{8'h01, 1'b0, 12'b0_1_1_00000001_0};
    vecs[3] = '{8'h80, 1'b1, 12'b0_1_0_10000000_0};
    vecs[4] = '{8'hFF, 1'b0, 12'b0_1_0_11111111_0};
    vecs[5] = '{8'h00, 1'b0, 12'b0_1_0_00000000_0};
    vecs[6] = '{8'h3C, 1'b1, 12'b0_1_1_00111100_0};
`else
    vecs[0] = '{8'hA5, 1'b0, 12'b00_1_10100101_0};
    vecs[1] = '{8'hA5, 1'b1, 12'b00_1_10100101_0};
    vecs[2] = '{8'h01, 1'b0, 12'b00_1_00000001_0};
    vecs[3] = '{8'h80, 1'b1, 12'b00_1_10000000_0};
    vecs[4] = '{8'hFF, 1'b0, 12'b00_1_11111111_0};
    vecs[5] = '{8'h00, 1'b0, 12'b00_1_00000000_0};
    vecs[6] = '{8'h3C, 1'b1, 12'b00_1_00111100_0};
`endif
    n_vec = 0;
    n_fail = 0;
    rst_i = 1'b1;
    enable_i = 1'b1;
    parity_odd_i = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_d_ready_i = 1'b0;
    fifo_rdata_i = 8'hEE;
    fetch_pending = 1'b0;
    force_empty = 1'b0;
    withhold = 0;
    pops = 0;
    fetches = 0;

    #12;
    check("reset txd", txd_o, 1);
    check("reset busy", busy_o, 0);
    check("reset done", done_o, 0);
    check("reset re", fifo_re_o, 0);
    check("reset tr_bz", fifo_tr_bz_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Enabled but nothing to send: the line must stay idle.
    repeat (20) tick();
    check("idle fetches", fetches, 0);
    check("idle txd", txd_o, 1);
    check("idle busy", busy_o, 0);

    for (int i = 0; i < NVEC; i++) begin
      p0 = pops;
      f0 = fetches;
      parity_odd_i = vecs[i].odd;
      push(vecs[i].data);
      run_frame($sformatf("vec%0d", i), vecs[i].bits, 3, -1);
      tick();
      check($sformatf("vec%0d idle busy", i), busy_o, 0);
      check($sformatf("vec%0d idle txd", i), txd_o, 1);
      check($sformatf("vec%0d pops", i), pops - p0, 1);
      check($sformatf("vec%0d fetches", i), fetches - f0, 1);
    end
    parity_odd_i = 1'b0;

    // Back-to-back: latency 3 on the second frame means exactly two high clocks.
    p0 = pops;
    push(8'h01);
    push(8'h80);
    run_frame("b2b first", F_01, 3, -1);
    run_frame("b2b second", F_80, 3, -1);
    tick();
    check("b2b pops", pops - p0, 2);
    check("b2b busy after", busy_o, 0);

    // A write steals the pop cycle: controller refetches and sends the byte once.
    p0 = pops;
    f0 = fetches;
    withhold = 1;
    push(8'h3C);
    run_frame("collide", F_3C, 5, -1);
    tick();
    check("collide pops", pops - p0, 1);
    check("collide fetches", fetches - f0, 2);
    check("collide fifo left", fifo_q.size(), 0);

    // No pop and FIFO reads empty in WAIT: drop back to IDLE without a frame.
    p0 = pops;
    f0 = fetches;
    push(8'h0F);
    tick();
    check("fetch re", fifo_re_o, 1);
    check("fetch tr_bz", fifo_tr_bz_o, 0);
    withhold = 1;
    force_empty = 1'b1;
    fifo_empty_i = 1'b1;
    tick();
    check("wait tr_bz", fifo_tr_bz_o, 1);
    check("wait re", fifo_re_o, 0);
    tick();
    check("empty-wait busy", busy_o, 0);
    check("empty-wait tr_bz", fifo_tr_bz_o, 0);
    repeat (6) tick();
    check("empty-wait txd", txd_o, 1);
    check("empty-wait fetches", fetches - f0, 1);
    force_empty = 1'b0;
    fifo_empty_i = 1'b0;
    run_frame("after empty-wait", F_0F, 3, -1);
    tick();
    check("after empty-wait pops", pops - p0, 1);

    // Enable dropped mid-DATA: frame completes, next byte waits for re-enable.
    p0 = pops;
    f0 = fetches;
    push(8'h3C);
    push(8'hA5);
    run_frame("enable drop", F_3C, 3, 10);
    repeat (8) tick();
    check("disabled busy", busy_o, 0);
    check("disabled fetches", fetches - f0, 1);
    check("disabled fifo left", fifo_q.size(), 1);
    enable_i = 1'b1;
    run_frame("enable resume", F_A5, 3, -1);
    tick();
    check("enable pops", pops - p0, 2);

    // Reset during data bit 3 (a 0 for 0xA5): line returns high without a clock.
    push(8'hA5);
    lat = 0;
    while (txd_o !== 1'b0 && lat < 20) begin
      tick();
      lat++;
    end
    check("rst frame latency", lat, 3);
    repeat (17) tick();
    check("pre-reset txd", txd_o, 0);
    check("pre-reset busy", busy_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("async reset txd", txd_o, 1);
    check("async reset busy", busy_o, 0);
    check("async reset tr_bz", fifo_tr_bz_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    fetch_pending = 1'b0;
    f0 = fetches;
    repeat (10) tick();
    check("post-reset busy", busy_o, 0);
    check("post-reset txd", txd_o, 1);
    check("post-reset done", done_o, 0);
    check("post-reset fetches", fetches - f0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
